// File: rtl/comparer_pkg.sv
// Shared encodings and sizing helpers for the N-bit magnitude comparator.
package comparer_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GT   = 2'd1,
        RES_EQ   = 2'd2,
        RES_LT   = 2'd3
    } res_e;

    // Counter must be able to hold the value stable_cnt itself.
    function automatic int unsigned cnt_width(input int unsigned stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/comparer_if.sv
// Operand/result bundle between a compare source and the comparer_n block.
interface comparer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             led1;
    logic             led2;
    logic             led3;

    modport master (
        output in_valid, a, b, signed_mode,
        input  out_valid, gt, eq, lt, led1, led2, led3
    );

    modport slave (
        input  in_valid, a, b, signed_mode,
        output out_valid, gt, eq, lt, led1, led2, led3
    );
endinterface

// File: rtl/comparer_n_stable_filter.sv
// Debounces the compare result: disp only changes after STABLE_CNT identical valid results.
module stable_filter
    import comparer_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [1:0] res,
    output logic [1:0] disp
);
    localparam int unsigned     CW      = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CNT);

    res_e          cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // A new result restarts the run; a repeat extends it, saturating at CNT_MAX.
    always_comb begin
        cnt_nxt = cnt;
        if (res != cand) begin
            cnt_nxt = CW'(1);
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= RES_NONE;
            cnt  <= '0;
            disp <= RES_NONE;
        end else if (res_valid) begin
            cand <= res_e'(res);
            cnt  <= cnt_nxt;
            if (cnt_nxt == CNT_MAX) begin
                disp <= res;
            end
        end
    end
endmodule

// File: rtl/comparer_n.sv
// Registered N-bit unsigned/two's-complement comparator with debounced LED outputs.
module comparer_n
    import comparer_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned STABLE_CNT     = 4,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    comparer_if.slave  bus
);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sm_q;
    logic             v1;
    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;
    res_e             res_c;
    logic             out_valid_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic [1:0]       disp;
    logic             led1_q;
    logic             led2_q;
    logic             led3_q;

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            sm_q <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                sm_q <= bus.signed_mode;
            end
        end
    end

    always_comb begin
        ka    = a_q ^ (sm_q ? MSB_MASK : '0);
        kb    = b_q ^ (sm_q ? MSB_MASK : '0);
        res_c = RES_LT;
        if (ka > kb) begin
            res_c = RES_GT;
        end else if (ka == kb) begin
            res_c = RES_EQ;
        end
    end

    // Stage 2: registered flags, held between valid results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            out_valid_q <= v1;
            if (v1) begin
                gt_q <= (res_c == RES_GT);
                eq_q <= (res_c == RES_EQ);
                lt_q <= (res_c == RES_LT);
            end
        end
    end

    // Filter sees the same sample on the same edge that the flags register it.
    stable_filter #(
        .STABLE_CNT (STABLE_CNT)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (v1),
        .res       (res_c),
        .disp      (disp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led1_q <= LED_ACTIVE_LOW;
            led2_q <= LED_ACTIVE_LOW;
            led3_q <= LED_ACTIVE_LOW;
        end else begin
            led1_q <= (disp == RES_GT) ^ LED_ACTIVE_LOW;
            led2_q <= (disp == RES_EQ) ^ LED_ACTIVE_LOW;
            led3_q <= (disp == RES_LT) ^ LED_ACTIVE_LOW;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.gt        = gt_q;
    assign bus.eq        = eq_q;
    assign bus.lt        = lt_q;
    assign bus.led1      = led1_q;
    assign bus.led2      = led2_q;
    assign bus.led3      = led3_q;
endmodule

// File: tb/tb_comparer_n.sv
// Directed bench for comparer_n: 8-bit active-low instance plus a 1-bit active-high instance.
module tb_comparer_n;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    comparer_if #(.WIDTH(8)) bus ();
    comparer_if #(.WIDTH(1)) bus1 ();

    comparer_n #(
        .WIDTH          (8),
        .STABLE_CNT     (4),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    comparer_n #(
        .WIDTH          (1),
        .STABLE_CNT     (1),
        .LED_ACTIVE_LOW (1'b0)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [3:0] flags;
    logic [2:0] leds;
    logic [3:0] flags1;
    logic [2:0] leds1;
    assign flags  = {bus.out_valid, bus.gt, bus.eq, bus.lt};
    assign leds   = {bus.led1, bus.led2, bus.led3};
    assign flags1 = {bus1.out_valid, bus1.gt, bus1.eq, bus1.lt};
    assign leds1  = {bus1.led1, bus1.led2, bus1.led3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic s);
        bus.in_valid    = v;
        bus.a           = x;
        bus.b           = y;
        bus.signed_mode = s;
    endtask

    task automatic apply_reset;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++;
        if (flags !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000", flags); errors++;
        end
        checks++;
        if (leds !== 3'b111) begin
            $display("FAIL reset_leds: got %b expected 111", leds); errors++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({flags, leds} !== 7'b0000_111) begin
                $display("FAIL idle_after_reset[%0d]: got %b expected 0000111", i, {flags, leds}); errors++;
            end
        end
    endtask

    task automatic test_unsigned_latency;
        drive(1'b1, 8'hC8, 8'h32, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        checks++;
        if (flags !== 4'b0000) begin
            $display("FAIL latency_early: got %b expected 0000", flags); errors++;
        end
        tick();
        checks++;
        if (flags !== 4'b1100) begin
            $display("FAIL unsigned_gt: got %b expected 1100", flags); errors++;
        end
        tick();
        checks++;
        if (flags !== 4'b0100) begin
            $display("FAIL flags_hold: got %b expected 0100", flags); errors++;
        end
    endtask

    task automatic test_signed;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vs [3];
        logic [3:0] exp [3];
        va = '{8'hC8, 8'h80, 8'h80};
        vb = '{8'h32, 8'h7F, 8'h7F};
        vs = '{1'b1, 1'b1, 1'b0};
        exp = '{4'b1001, 4'b1001, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i], vb[i], vs[i]);
            tick();
            drive(1'b0, 8'h00, 8'h00, 1'b0);
            tick();
            checks++;
            if (flags !== exp[i]) begin
                $display("FAIL signed_cmp[%0d]: got %b expected %b", i, flags, exp[i]); errors++;
            end
        end
    endtask

    task automatic test_filter_run;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 8'h55, 8'h55, 1'b0);
            tick();
            if (i == 4) begin
                checks++;
                if ({flags, leds} !== 7'b1010_111) begin
                    $display("FAIL eq_4th_sample: got %b expected 1010111", {flags, leds}); errors++;
                end
            end
        end
        checks++;
        if (leds !== 3'b101) begin
            $display("FAIL eq_led_on: got %b expected 101", leds); errors++;
        end
        // Three gt then one eq: count never completes, LEDs keep eq
        for (int i = 0; i < 10; i++) begin
            if (i < 3)       drive(1'b1, 8'h90, 8'h10, 1'b0);
            else if (i == 3) drive(1'b1, 8'h33, 8'h33, 1'b0);
            else             drive(1'b0, 8'h00, 8'h00, 1'b0);
            tick();
            checks++;
            if (leds !== 3'b101) begin
                $display("FAIL interrupted_run[%0d]: got %b expected 101", i, leds); errors++;
            end
        end
    endtask

    task automatic test_gaps;
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 8'h0A, 8'h0A, 1'b0);
            tick();
            drive(1'b0, 8'h00, 8'h00, 1'b0);
            for (int g = 0; g < 5; g++) tick();
            checks++;
            if (leds !== ((s == 3) ? 3'b101 : 3'b111)) begin
                $display("FAIL gap_sample[%0d]: got %b expected %b", s, leds,
                         (s == 3) ? 3'b101 : 3'b111); errors++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 8'hF0, 8'h0F, 1'b0);
            tick();
            checks++;
            if (leds !== ((i == 5) ? 3'b011 : 3'b101)) begin
                $display("FAIL eq_to_gt[%0d]: got %b expected %b", i, leds,
                         (i == 5) ? 3'b011 : 3'b101); errors++;
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 8'h77, 8'h77, 1'b0);
            tick();
        end
        checks++;
        if (leds !== 3'b101) begin
            $display("FAIL pre_reset_eq: got %b expected 101", leds); errors++;
        end
        drive(1'b1, 8'h77, 8'h77, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({flags, leds} !== 7'b0000_111) begin
            $display("FAIL async_reset: got %b expected 0000111", {flags, leds}); errors++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (flags !== 4'b0000) begin
            $display("FAIL inflight_discard: got %b expected 0000", flags); errors++;
        end
        drive(1'b1, 8'h77, 8'h77, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        checks++;
        if (flags !== 4'b1010) begin
            $display("FAIL post_reset_sample: got %b expected 1010", flags); errors++;
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (leds !== 3'b111) begin
            $display("FAIL single_sample_dark: got %b expected 111", leds); errors++;
        end
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 8'h77, 8'h77, 1'b0);
            tick();
            checks++;
            if (leds !== ((i == 4) ? 3'b101 : 3'b111)) begin
                $display("FAIL fresh_run[%0d]: got %b expected %b", i, leds,
                         (i == 4) ? 3'b101 : 3'b111); errors++;
            end
        end
    endtask

    task automatic test_width1;
        logic       va [3];
        logic       vb [3];
        logic       vs [3];
        logic [3:0] ef [3];
        logic [2:0] el [3];
        va = '{1'b1, 1'b1, 1'b1};
        vb = '{1'b0, 1'b0, 1'b1};
        vs = '{1'b1, 1'b0, 1'b1};
        ef = '{4'b1001, 4'b1100, 4'b1010};
        el = '{3'b001, 3'b100, 3'b010};
        checks++;
        if (leds1 !== 3'b000) begin
            $display("FAIL w1_reset_leds: got %b expected 000", leds1); errors++;
        end
        for (int i = 0; i < 3; i++) begin
            bus1.in_valid = 1'b1; bus1.a = va[i]; bus1.b = vb[i]; bus1.signed_mode = vs[i];
            tick();
            bus1.in_valid = 1'b0;
            tick();
            checks++;
            if (flags1 !== ef[i]) begin
                $display("FAIL w1_flags[%0d]: got %b expected %b", i, flags1, ef[i]); errors++;
            end
            tick();
            checks++;
            if (leds1 !== el[i]) begin
                $display("FAIL w1_leds[%0d]: got %b expected %b", i, leds1, el[i]); errors++;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.signed_mode = 1'b0;
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_filter_run();
        test_gaps();
        test_reset_mid();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
